// File: rtl/imm_extend_if.sv
// Request/response bundle for the immediate extender: request handshake in,
// result handshake out, plus the running illegal-encoding count.
interface imm_extend_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      Instr;
    logic [2:0]       ImmSrc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ExtImm;
    logic             ImmCarry;
    logic             ImmErr;
    logic [7:0]       ErrCount;

    modport slave (
        input  in_valid, Instr, ImmSrc, out_ready,
        output in_ready, out_valid, ExtImm, ImmCarry, ImmErr, ErrCount
    );

    modport master (
        output in_valid, Instr, ImmSrc, out_ready,
        input  in_ready, out_valid, ExtImm, ImmCarry, ImmErr, ErrCount
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender: stage 1 captures the raw fields,
// stage 2 forms the WIDTH-bit immediate, shifter carry and illegal-encoding flag.
module imm_extend_pipe #(
    parameter int WIDTH    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    imm_extend_if.slave bus
);
    logic             s1_valid_q;
    logic [23:0]      instr_q;
    logic [2:0]       src_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] ext_q, ext_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             s1_en, s2_en;

    assign s2_en        = !out_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid_q || s2_en;
    assign bus.in_ready = s1_en;

    // Rotated data-processing immediate; a zero rotate makes the left term vanish.
    logic [31:0] imm8_32, rot_imm;
    logic [5:0]  rot;
    assign imm8_32 = {24'd0, instr_q[7:0]};
    assign rot     = {1'b0, instr_q[11:8], 1'b0};
    assign rot_imm = (imm8_32 >> rot) | (imm8_32 << (6'd32 - rot));

    logic [WIDTH-1:0] br_sext, off12;
    assign br_sext = WIDTH'($signed(instr_q));
    assign off12   = WIDTH'(instr_q[11:0]);

    always_comb begin
        ext_d   = '0;
        carry_d = 1'b0;
        err_d   = 1'b0;
        unique case (src_q)
            3'b000: ext_d = WIDTH'(instr_q[7:0]);
            3'b001: ext_d = off12;
            3'b010: ext_d = br_sext << BR_SHIFT;
            3'b011: begin
                ext_d   = WIDTH'(rot_imm);
                carry_d = (instr_q[11:8] != 4'd0) && rot_imm[31];
            end
            3'b100: ext_d = WIDTH'({instr_q[11:8], instr_q[3:0]});
            3'b101: ext_d = instr_q[23] ? off12 : -off12;
            default: err_d = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && bus.out_ready && err_q && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            instr_q    <= '0;
            src_q      <= '0;
        end else if (s1_en) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                instr_q <= bus.Instr;
                src_q   <= bus.ImmSrc;
            end
        end
    end

    // Data registers only load on a real result so a bubble leaves them stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            ext_q       <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (s2_en) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    ext_q   <= ext_d;
                    carry_q <= carry_d;
                    err_q   <= err_d;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ExtImm    = ext_q;
    assign bus.ImmCarry  = carry_q;
    assign bus.ImmErr    = err_q;
    assign bus.ErrCount  = cnt_q;
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate extender for the ARM datapath. It turns the low 24 instruction bits into a WIDTH-bit immediate. It supports every immediate form the decoder needs: zero-extended, rotated data-processing, split halfword, U-bit signed offset, and sign-extended scaled branch. It sits between the decode register and the execute operand mux. A two-stage valid/ready pipeline lets it stall with the rest of the front end, and it flags and counts illegal ImmSrc encodings.

## Interface
- WIDTH, 32, output immediate width; legal range 32..64.
- BR_SHIFT, 2, left shift applied to branch offsets; legal range 0..3.

- clk  in  1  single clock; every register updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  Instr/ImmSrc carry a request.
- in_ready  out  1  block accepts a request this cycle.
- Instr  in  24  instruction bits [23:0].
- ImmSrc  in  3  immediate form select.
- out_valid  out  1  ExtImm/ImmCarry/ImmErr hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- ExtImm  out  WIDTH  extended immediate.
- ImmCarry  out  1  shifter carry-out of the rotated immediate.
- ImmErr  out  1  result came from an illegal ImmSrc.
- ErrCount  out  8  saturating count of delivered illegal results.

## Operation
- Forms by ImmSrc, always computed at 32 bits, then zero-extended to WIDTH unless stated otherwise:
  - 000: zero-extend Instr[7:0].
  - 001: zero-extend Instr[11:0].
  - 010: sign-extend Instr[23:0] to WIDTH, then shift left by BR_SHIFT. Bits shifted past WIDTH-1 are dropped.
  - 011: Instr[7:0] rotated right within 32 bits by 2*Instr[11:8]. ImmCarry = bit 31 of the result when Instr[11:8]!=0, else 0.
  - 100: zero-extend {Instr[11:8], Instr[3:0]}.
  - 101: Instr[23] (U bit) =1 gives zero-extended Instr[11:0]. U=0 gives the WIDTH-bit two's-complement negation of it. Offset 0 with U=0 gives 0.
  - 110, 111: ExtImm=0, ImmCarry=0, ImmErr=1.
- ImmCarry is 0 for every form other than 011. ImmErr is 0 for every legal form.
- Stage 1 registers Instr, ImmSrc and s1_valid.
- Stage 2 computes the form from the stage-1 registers and registers ExtImm, ImmCarry, ImmErr and out_valid.
- Enables:
  - s2_en = !out_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en (combinational path from out_ready is intentional)
- A request is accepted when in_valid & in_ready.
- Stage 2 loads s1_valid and result when s2_en. When s1_valid=0, out_valid clears and the data registers hold.
- ErrCount increments by 1 on each output handshake (out_valid & out_ready) with ImmErr=1. It saturates at 255 and clears only on reset.

## Timing
- Reset (reset_n low, asynchronous) forces:
  - s1_valid=0, out_valid=0.
  - ExtImm=0, ImmCarry=0, ImmErr=0, ErrCount=0.
  - in_ready=1 while reset_n is low and on the first cycle after release.
- Latency: a request accepted at edge k appears with out_valid=1 after edge k+1 when there is no stall. Throughput is 1 per cycle.
- Stall: while out_valid=1 and out_ready=0, ExtImm, ImmCarry and ImmErr hold stable.
- Under a stall, stage 1 still absorbs one more request, then in_ready=0.
- in_ready rises in the same cycle that out_ready rises.
- Ordering is strictly FIFO. A request is never dropped and never duplicated.
- Simultaneous output handshake and new acceptance in the same cycle: both stages advance with no bubble.
- Reset asserted mid-stream flushes both stages. No result from before reset is ever presented.
- in_valid may drop without handshake. in_valid and the request fields are ignored while in_ready=0.

## Test plan
- ImmSrc=011, Instr=0x0002FF, out_ready=1 -> ExtImm=0xF000000F, ImmCarry=1, one cycle after acceptance. Then Instr=0x0000AB -> ExtImm=0x000000AB, ImmCarry=0.
- ImmSrc=010, WIDTH=32, BR_SHIFT=2: Instr=0x800000 -> 0xFE000000; Instr=0x000003 -> 0x0000000C. WIDTH=64: Instr=0x800000 -> 0xFFFFFFFFFE000000.
- ImmSrc=101: Instr=0x000004 -> 0xFFFFFFFC; Instr=0x800004 -> 0x00000004; Instr=0x000000 -> 0x00000000. ImmSrc=100, Instr=0x000A05 -> 0x000000A5.
- Four back-to-back requests (ImmSrc=000, Instr[7:0]=1,2,3,4) with out_ready=0 for 4 cycles:
  - in_ready goes low after the 2nd acceptance.
  - ExtImm stays at 1 throughout the stall.
  - After out_ready=1, results arrive as 1,2,3,4 on consecutive cycles.
- 300 illegal requests (ImmSrc=110/111) with out_ready=1 -> each gives ExtImm=0, ImmErr=1, and ErrCount ends at 255. A legal request afterwards gives ImmErr=0 and leaves ErrCount at 255.
- Two requests in flight, reset_n pulsed low mid-cycle:
  - all outputs reach reset values immediately, without waiting for a clock edge.
  - After release, out_valid stays 0 until a new request is accepted.
